// File: rtl/alu_decoder_cond.sv
// rtl/alu_decoder_cond.sv - ALU control decode, NZCV flag register and condition-gated write enables
module alu_decoder_cond #(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [1:0]        Sh,
    input  logic [3:0]        Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              PCS,
    output logic [3:0]        ALUControl,
    output logic              NoWrite,
    output logic              CondEx,
    output logic [FLAG_W-1:0] Flags,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              PCSrc
);

    logic [FLAG_W-1:0] r_flags;
    logic [3:0]        w_cmd;
    logic              w_s;
    logic              w_fw_nz;
    logic              w_fw_cv;
    logic              w_n, w_z, w_c, w_v;
    logic              w_upd_nz;
    logic              w_upd_cv;
    logic              w_unused;

    assign w_cmd    = Funct[4:1];
    assign w_s      = Funct[0];
    assign w_unused = Funct[5];

    always_comb begin
        ALUControl = 4'b0000;
        NoWrite    = 1'b0;
        w_fw_nz    = 1'b0;
        w_fw_cv    = 1'b0;
        case (Op)
            2'b00: begin
                case (w_cmd)
                    4'b0100: begin ALUControl = 4'b0000; w_fw_nz = w_s; w_fw_cv = w_s; end
                    4'b0010: begin ALUControl = 4'b0001; w_fw_nz = w_s; w_fw_cv = w_s; end
                    4'b0000: begin ALUControl = 4'b0010; w_fw_nz = w_s; end
                    4'b1100: begin ALUControl = 4'b0011; w_fw_nz = w_s; end
                    4'b0001: begin ALUControl = 4'b0100; w_fw_nz = w_s; end
                    // CMP always writes flags, regardless of the S bit
                    4'b1010: begin
                        ALUControl = 4'b0001;
                        NoWrite    = 1'b1;
                        w_fw_nz    = 1'b1;
                        w_fw_cv    = 1'b1;
                    end
                    4'b1101: begin
                        w_fw_nz = w_s;
                        case (Sh)
                            2'b00:   ALUControl = 4'b0101;
                            2'b01:   ALUControl = 4'b0110;
                            2'b10:   ALUControl = 4'b0111;
                            default: ALUControl = 4'b1000;
                        endcase
                    end
                    default: NoWrite = 1'b1;
                endcase
            end
            2'b11:   NoWrite = 1'b1;
            default: NoWrite = 1'b0;
        endcase
    end

    // Condition is judged against the architectural flags, not this cycle's ALU result
    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = w_z;
            4'b0001: CondEx = ~w_z;
            4'b0010: CondEx = w_c;
            4'b0011: CondEx = ~w_c;
            4'b0100: CondEx = w_n;
            4'b0101: CondEx = ~w_n;
            4'b0110: CondEx = w_v;
            4'b0111: CondEx = ~w_v;
            4'b1000: CondEx = w_c & ~w_z;
            4'b1001: CondEx = ~w_c | w_z;
            4'b1010: CondEx = (w_n == w_v);
            4'b1011: CondEx = (w_n != w_v);
            4'b1100: CondEx = ~w_z & (w_n == w_v);
            4'b1101: CondEx = w_z | (w_n != w_v);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    assign w_upd_nz = instr_valid & CondEx & w_fw_nz;
    assign w_upd_cv = instr_valid & CondEx & w_fw_cv;

    assign RegWrite = RegW & CondEx & ~NoWrite & instr_valid;
    assign MemWrite = MemW & CondEx & instr_valid;
    assign PCSrc    = PCS & CondEx & instr_valid;
    assign Flags    = r_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else begin
            if (w_upd_nz) r_flags[3:2] <= ALUFlags[3:2];
            if (w_upd_cv) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_alu_decoder_cond.sv
// tb/tb_alu_decoder_cond.sv - directed vectors with a queued scoreboard for alu_decoder_cond
module tb_alu_decoder_cond;

    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [1:0] Sh;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic       RegW;
    logic       MemW;
    logic       PCS;
    logic [3:0] ALUControl;
    logic       NoWrite;
    logic       CondEx;
    logic [3:0] Flags;
    logic       RegWrite;
    logic       MemWrite;
    logic       PCSrc;

    typedef struct packed {
        logic [3:0] ctl;
        logic       nw;
        logic       cx;
        logic [3:0] flg;
        logic       rw;
        logic       mw;
        logic       pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   vec_id;

    alu_decoder_cond #(.FLAG_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .Op         (Op),
        .Funct      (Funct),
        .Sh         (Sh),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .RegW       (RegW),
        .MemW       (MemW),
        .PCS        (PCS),
        .ALUControl (ALUControl),
        .NoWrite    (NoWrite),
        .CondEx     (CondEx),
        .Flags      (Flags),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .PCSrc      (PCSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %b expected %b", id, name, act, exp);
        end
    endtask

    // Monitor: one response per driven cycle, sampled on the falling edge
    int mon_id = 0;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ALUControl", mon_id, ALUControl, e.ctl);
            check("NoWrite",    mon_id, {3'b0, NoWrite},  {3'b0, e.nw});
            check("CondEx",     mon_id, {3'b0, CondEx},   {3'b0, e.cx});
            check("Flags",      mon_id, Flags, e.flg);
            check("RegWrite",   mon_id, {3'b0, RegWrite}, {3'b0, e.rw});
            check("MemWrite",   mon_id, {3'b0, MemWrite}, {3'b0, e.mw});
            check("PCSrc",      mon_id, {3'b0, PCSrc},    {3'b0, e.pc});
            mon_id++;
        end
    end

    task automatic apply(
        input logic rst, input logic vld, input logic [1:0] op, input logic [5:0] fn,
        input logic [1:0] sh, input logic [3:0] cnd, input logic [3:0] af,
        input logic rgw, input logic mmw, input logic pcs,
        input logic [3:0] e_ctl, input logic e_nw, input logic e_cx, input logic [3:0] e_flg,
        input logic e_rw, input logic e_mw, input logic e_pc);
        exp_t e;
        #1;
        reset = rst; instr_valid = vld; Op = op; Funct = fn; Sh = sh; Cond = cnd;
        ALUFlags = af; RegW = rgw; MemW = mmw; PCS = pcs;
        e.ctl = e_ctl; e.nw = e_nw; e.cx = e_cx; e.flg = e_flg;
        e.rw = e_rw; e.mw = e_mw; e.pc = e_pc;
        exp_q.push_back(e);
        vec_id++;
        @(posedge clk);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; vec_id = 0;
        reset = 1'b1; instr_valid = 1'b0; Op = 2'b00; Funct = 6'b0; Sh = 2'b00;
        Cond = 4'b1110; ALUFlags = 4'b0; RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;
        @(posedge clk);
        //     rst vld op     funct      sh     cond     aluf     rw mw pc | ctl     nw cx flags    rw mw pc
        apply(1, 0, 2'b00, 6'b000000, 2'b00, 4'b1110, 4'b0000, 1, 0, 0, 4'b0010, 0, 1, 4'b0000, 0, 0, 0);
        apply(0, 1, 2'b00, 6'b000101, 2'b00, 4'b1110, 4'b0110, 1, 0, 0, 4'b0001, 0, 1, 4'b0000, 1, 0, 0); // SUBS
        apply(0, 1, 2'b00, 6'b000001, 2'b00, 4'b1110, 4'b1000, 1, 0, 0, 4'b0010, 0, 1, 4'b0110, 1, 0, 0); // ANDS
        apply(0, 1, 2'b00, 6'b010101, 2'b00, 4'b1110, 4'b0100, 1, 0, 0, 4'b0001, 1, 1, 4'b1010, 0, 0, 0); // CMP
        apply(0, 1, 2'b10, 6'b000000, 2'b00, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000, 0, 1, 4'b0100, 0, 0, 1); // BEQ
        apply(0, 1, 2'b10, 6'b000000, 2'b00, 4'b0001, 4'b1111, 0, 0, 1, 4'b0000, 0, 0, 4'b0100, 0, 0, 0); // BNE
        apply(0, 1, 2'b00, 6'b011010, 2'b00, 4'b1110, 4'b1111, 1, 0, 0, 4'b0101, 0, 1, 4'b0100, 1, 0, 0); // MOV LSL
        apply(0, 1, 2'b00, 6'b011010, 2'b01, 4'b1110, 4'b1111, 1, 0, 0, 4'b0110, 0, 1, 4'b0100, 1, 0, 0); // MOV LSR
        apply(0, 1, 2'b00, 6'b011010, 2'b10, 4'b1110, 4'b1111, 1, 0, 0, 4'b0111, 0, 1, 4'b0100, 1, 0, 0); // MOV ASR
        apply(0, 1, 2'b00, 6'b011010, 2'b11, 4'b1110, 4'b1111, 1, 0, 0, 4'b1000, 0, 1, 4'b0100, 1, 0, 0); // MOV ROR
        apply(0, 1, 2'b00, 6'b001001, 2'b00, 4'b1110, 4'b1001, 1, 0, 0, 4'b0000, 0, 1, 4'b0100, 1, 0, 0); // ADDS -> 1001
        apply(0, 1, 2'b10, 6'b000000, 2'b00, 4'b1010, 4'b0000, 0, 0, 1, 4'b0000, 0, 1, 4'b1001, 0, 0, 1); // GE
        apply(0, 1, 2'b10, 6'b000000, 2'b00, 4'b1011, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 4'b1001, 0, 0, 0); // LT
        apply(0, 1, 2'b10, 6'b000000, 2'b00, 4'b1100, 4'b0000, 0, 0, 1, 4'b0000, 0, 1, 4'b1001, 0, 0, 1); // GT
        apply(0, 1, 2'b00, 6'b001001, 2'b00, 4'b1111, 4'b0110, 1, 1, 1, 4'b0000, 0, 0, 4'b1001, 0, 0, 0); // NV ADDS
        apply(0, 1, 2'b01, 6'b000000, 2'b00, 4'b1110, 4'b0000, 1, 1, 0, 4'b0000, 0, 1, 4'b1001, 1, 1, 0); // memory
        apply(1, 1, 2'b00, 6'b001001, 2'b00, 4'b1110, 4'b0110, 1, 0, 0, 4'b0000, 0, 1, 4'b1001, 1, 0, 0); // ADDS + reset
        apply(0, 0, 2'b00, 6'b001001, 2'b00, 4'b1110, 4'b1111, 1, 0, 0, 4'b0000, 0, 1, 4'b0000, 0, 0, 0); // ADDS invalid
        apply(0, 1, 2'b11, 6'b000001, 2'b00, 4'b1110, 4'b1111, 1, 0, 0, 4'b0000, 1, 1, 4'b0000, 0, 0, 0); // reserved Op
        apply(0, 1, 2'b00, 6'b000011, 2'b00, 4'b1110, 4'b1111, 1, 0, 0, 4'b0100, 0, 1, 4'b0000, 1, 0, 0); // EORS
        apply(0, 1, 2'b00, 6'b011000, 2'b00, 4'b1110, 4'b0011, 1, 0, 0, 4'b0011, 0, 1, 4'b1100, 1, 0, 0); // ORR
        apply(0, 1, 2'b00, 6'b000111, 2'b00, 4'b1110, 4'b1111, 1, 0, 0, 4'b0000, 1, 1, 4'b1100, 0, 0, 0); // undefined cmd
        apply(0, 1, 2'b10, 6'b000000, 2'b00, 4'b1101, 4'b0000, 0, 0, 1, 4'b0000, 0, 1, 4'b1100, 0, 0, 1); // LE
        apply(0, 1, 2'b10, 6'b000000, 2'b00, 4'b1000, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 4'b1100, 0, 0, 0); // HI
        instr_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses still queued, expected 0", exp_q.size());
        end
        n_checks++;
        if (mon_id != vec_id) begin
            n_fail++;
            $display("FAIL count: monitor checked %0d vectors, expected %0d", mon_id, vec_id);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
